pc_sequencer: RTL and testbench

Program-counter sequencer for the 64-bit core. It replaces the free-standing branch-target adder with a parametrised registered unit. The unit holds the PC and computes the sequential and branch targets internally, with a configurable offset shift. Each cycle it selects the next PC by fixed priority, and it tracks a sticky misalignment error plus a saturating taken-branch counter. It sits between the sign-extend unit and control unit on the input side and instruction memory on the output side.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/branch_target_adder.sv | 19 +
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Holds the next-PC source encoding, default widths and the alignment mask helper.
package pc_seq_pkg;

    localparam int unsigned DEFAULT_XLEN       = 64;
    localparam int unsigned DEFAULT_INST_BYTES = 4;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_PCREL,
        SRC_REG,
        SRC_REDIR,
        SRC_HOLD
    } nextSrc_e;

    // Low address bits that must be zero for an instruction-aligned target.
    function automatic logic [63:0] alignMask(input int unsigned instBytes);
        return 64'(instBytes) - 64'd1;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational PC-relative target: pc + (offset << SHIFT), modulo 2^XLEN.
// Bits shifted above XLEN-1 are discarded; no carry or overflow is reported.
module branch_target_adder #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned SHIFT = 2
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] shiftedOffset;

    always_comb begin
        shiftedOffset = offset << SHIFT;
        target        = pc + shiftedOffset;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: fixed-priority next-PC selection,
// sticky misalignment status and a saturating taken-branch counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN       = DEFAULT_XLEN,
    parameter int unsigned     SHIFT      = 2,
    parameter int unsigned     INST_BYTES = DEFAULT_INST_BYTES,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [XLEN-1:0]  seu_offset,
    input  logic             branch_uncond,
    input  logic             branch_cond,
    input  logic             zero_flag,
    input  logic             branch_reg,
    input  logic [XLEN-1:0]  reg_target,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus,
    output logic [XLEN-1:0]  branch_target,
    output logic             taken_q,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(alignMask(INST_BYTES));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

    nextSrc_e         nextSrc;
    logic [XLEN-1:0]  candidate;
    logic             takenPcrel;
    logic             candMisaligned;
    logic [XLEN-1:0]  pcNext;
    logic             takenNext;
    logic             errNext;
    logic [CNT_W-1:0] countNext;

    branch_target_adder #(
        .XLEN  (XLEN),
        .SHIFT (SHIFT)
    ) u_targetAdder (
        .pc     (pc),
        .offset (seu_offset),
        .target (branch_target)
    );

    assign pc_plus    = pc + PC_STEP;
    assign takenPcrel = branch_uncond | (branch_cond & zero_flag);

    always_comb begin
        nextSrc   = SRC_SEQ;
        candidate = pc_plus;
        if (redirect_valid) begin
            nextSrc   = SRC_REDIR;
            candidate = redirect_pc;
        end else if (stall) begin
            nextSrc   = SRC_HOLD;
            candidate = pc;
        end else if (branch_reg) begin
            nextSrc   = SRC_REG;
            candidate = reg_target;
        end else if (takenPcrel) begin
            nextSrc   = SRC_PCREL;
            candidate = branch_target;
        end
    end

    assign candMisaligned = (candidate & ALIGN_MASK) != '0;

    // Misaligned branch targets freeze the PC and raise status; redirects are never checked.
    always_comb begin
        pcNext    = pc;
        takenNext = taken_q;
        errNext   = misalign_err;
        countNext = taken_count;
        unique case (nextSrc)
            SRC_REDIR: begin
                pcNext    = candidate;
                takenNext = 1'b0;
                errNext   = 1'b0;
            end
            SRC_HOLD: begin
            end
            SRC_REG, SRC_PCREL: begin
                if (candMisaligned) begin
                    errNext   = 1'b1;
                    takenNext = 1'b0;
                end else begin
                    pcNext    = candidate;
                    takenNext = 1'b1;
                    if (taken_count != '1) begin
                        countNext = taken_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                pcNext    = pc_plus;
                takenNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc           <= RESET_PC;
            taken_q      <= 1'b0;
            misalign_err <= 1'b0;
            taken_count  <= '0;
        end else begin
            pc           <= pcNext;
            taken_q      <= takenNext;
            misalign_err <= errNext;
            taken_count  <= countNext;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with RESET_PC=0x1000 and a 2-bit counter.
// Expected values are hand-computed constants.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [63:0] seu_offset;
    logic        branch_uncond;
    logic        branch_cond;
    logic        zero_flag;
    logic        branch_reg;
    logic [63:0] reg_target;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pc;
    logic [63:0] pc_plus;
    logic [63:0] branch_target;
    logic        taken_q;
    logic        misalign_err;
    logic [1:0]  taken_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    pc_sequencer #(
        .XLEN       (64),
        .SHIFT      (2),
        .INST_BYTES (4),
        .RESET_PC   (64'h1000),
        .CNT_W      (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .seu_offset     (seu_offset),
        .branch_uncond  (branch_uncond),
        .branch_cond    (branch_cond),
        .zero_flag      (zero_flag),
        .branch_reg     (branch_reg),
        .reg_target     (reg_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .branch_target  (branch_target),
        .taken_q        (taken_q),
        .misalign_err   (misalign_err),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idleInputs();
        stall          = 1'b0;
        seu_offset     = '0;
        branch_uncond  = 1'b0;
        branch_cond    = 1'b0;
        zero_flag      = 1'b0;
        branch_reg     = 1'b0;
        reg_target     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [63:0] expPc, input logic expTaken,
                              input logic expErr, input logic [1:0] expCnt);
        checkVal({tag, ".pc"}, pc, expPc);
        checkVal({tag, ".taken"}, 64'(taken_q), 64'(expTaken));
        checkVal({tag, ".err"}, 64'(misalign_err), 64'(expErr));
        checkVal({tag, ".cnt"}, 64'(taken_count), 64'(expCnt));
    endtask

    task automatic redirectTo(input logic [63:0] target);
        idleInputs();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        idleInputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idleInputs();
        reset_n = 1'b0;
        step();
        checkState("reset", 64'h1000, 1'b0, 1'b0, 2'd0);
        checkVal("reset.pc_plus", pc_plus, 64'h1004);

        reset_n = 1'b1;
        step();
        checkVal("seq1.pc", pc, 64'h1004);
        step();
        checkVal("seq2.pc", pc, 64'h1008);
        step();
        checkState("seq3", 64'h100C, 1'b0, 1'b0, 2'd0);

        redirectTo(64'h2000);
        checkState("redir2000", 64'h2000, 1'b0, 1'b0, 2'd0);

        // CBZ taken with offset -4: 0x2000 + (-4 << 2) = 0x1FF0
        branch_cond = 1'b1;
        zero_flag   = 1'b1;
        seu_offset  = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        checkVal("cbz.target", branch_target, 64'h1FF0);
        step();
        checkState("cbzTaken", 64'h1FF0, 1'b1, 1'b0, 2'd1);
        zero_flag = 1'b0;
        step();
        checkState("cbzNotTaken", 64'h1FF4, 1'b0, 1'b0, 2'd1);

        redirectTo(64'h3000);
        branch_reg = 1'b1;
        reg_target = 64'h4002;
        step();
        checkState("misalignReg", 64'h3000, 1'b0, 1'b1, 2'd1);
        idleInputs();
        step();
        checkState("errAdvance", 64'h3004, 1'b0, 1'b1, 2'd1);
        redirectTo(64'h8000);
        checkState("redirClrErr", 64'h8000, 1'b0, 1'b0, 2'd1);

        branch_uncond = 1'b1;
        seu_offset    = 64'd4;
        step();
        checkState("uncond", 64'h8010, 1'b1, 1'b0, 2'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkState("stall", 64'h8010, 1'b1, 1'b0, 2'd2);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        checkState("stallRedir", 64'h100, 1'b0, 1'b0, 2'd2);

        idleInputs();
        branch_reg    = 1'b1;
        reg_target    = 64'h200;
        branch_uncond = 1'b1;
        seu_offset    = 64'd4;
        step();
        checkState("regBeatsPcrel", 64'h200, 1'b1, 1'b0, 2'd3);
        idleInputs();
        branch_uncond = 1'b1;
        seu_offset    = 64'd1;
        step();
        checkState("saturate1", 64'h204, 1'b1, 1'b0, 2'd3);
        step();
        checkState("saturate2", 64'h208, 1'b1, 1'b0, 2'd3);

        redirectTo(64'hFFFF_FFFF_FFFF_FFF8);
        step();
        checkVal("wrap.pcTop", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        checkVal("wrap.pc_plus", pc_plus, 64'h0);
        step();
        checkVal("wrap.pc", pc, 64'h0);
        seu_offset = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checkVal("wrap.target", branch_target, 64'hFFFF_FFFF_FFFF_FFFC);

        idleInputs();
        branch_reg = 1'b1;
        reg_target = 64'h6;
        step();
        checkState("misalign2", 64'h0, 1'b0, 1'b1, 2'd3);
        idleInputs();
        branch_uncond = 1'b1;
        seu_offset    = 64'd2;
        step();
        checkState("takenWithErr", 64'h8, 1'b1, 1'b1, 2'd3);
        reset_n = 1'b0;
        step();
        checkState("midReset", 64'h1000, 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
